// File: rtl/seg_frame_monitor.sv
// Glitch-filtered monitor for a seven-segment bus: accepts stable patterns, measures change period, flags stalls.
// Optional hex decode of the accepted pattern is built only when SEG_MON_HEX_DECODE_EN is defined.
`timescale 1ns/1ps
module seg_frame_monitor #(
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int PERIOD_W    = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          seg_in,
  output logic                frame_valid,
  output logic [7:0]          frame_pat,
  output logic [3:0]          digit,
  output logic                digit_ok,
  output logic [PERIOD_W-1:0] period,
  output logic [15:0]         frame_cnt,
  output logic                timeout
);

  localparam logic [7:0]          STABLE_V  = 8'(STABLE_CNT);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT_CYC);
  localparam logic [PERIOD_W-1:0] CTR_MAX   = '1;
  localparam logic [PERIOD_W-1:0] CTR_ONE   = PERIOD_W'(1);

  logic [7:0]          seg_q, seg_d;
  logic [7:0]          cand_q, cand_d;
  logic [7:0]          run_q, run_d;
  logic [7:0]          frame_pat_q, frame_pat_d;
  logic                frame_valid_q, frame_valid_d;
  logic [PERIOD_W-1:0] period_ctr_q, period_ctr_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                timeout_q, timeout_d;
  logic                seen_q, seen_d;
  logic                accept;

  always_comb begin
    seg_d = seg_in;
    if (seg_q == cand_q) begin
      cand_d = cand_q;
      run_d  = (run_q == STABLE_V) ? run_q : run_q + 8'd1;
    end else begin
      cand_d = seg_q;
      run_d  = 8'd1;
    end

    // Deciding on the next run count lets the accept land on the same edge the run completes.
    accept = (run_d == STABLE_V) && (cand_d != frame_pat_q);

    frame_valid_d = accept;
    frame_pat_d   = accept ? cand_d : frame_pat_q;
    seen_d        = seen_q | accept;
    frame_cnt_d   = accept ? frame_cnt_q + 16'd1 : frame_cnt_q;
    period_d      = (accept && seen_q) ? period_ctr_q : period_q;

    if (accept)
      period_ctr_d = CTR_ONE;
    else if (period_ctr_q == CTR_MAX)
      period_ctr_d = period_ctr_q;
    else
      period_ctr_d = period_ctr_q + CTR_ONE;

    timeout_d = !accept && (period_ctr_d >= TIMEOUT_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q         <= 8'h00;
      cand_q        <= 8'h00;
      run_q         <= 8'h00;
      frame_pat_q   <= 8'h00;
      frame_valid_q <= 1'b0;
      period_ctr_q  <= '0;
      period_q      <= '0;
      frame_cnt_q   <= 16'h0000;
      timeout_q     <= 1'b0;
      seen_q        <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      cand_q        <= cand_d;
      run_q         <= run_d;
      frame_pat_q   <= frame_pat_d;
      frame_valid_q <= frame_valid_d;
      period_ctr_q  <= period_ctr_d;
      period_q      <= period_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_q     <= timeout_d;
      seen_q        <= seen_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_pat   = frame_pat_q;
  assign period      = period_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout     = timeout_q;

`ifdef SEG_MON_HEX_DECODE_EN
  // Returns {ok, digit}; the decimal point is ignored.
  function automatic logic [4:0] hex_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  logic [3:0] digit_q, digit_d;
  logic       digit_ok_q, digit_ok_d;

  always_comb begin
    {digit_ok_d, digit_d} = hex_decode(frame_pat_d[6:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q    <= 4'h0;
      digit_ok_q <= 1'b0;
    end else begin
      digit_q    <= digit_d;
      digit_ok_q <= digit_ok_d;
    end
  end

  assign digit    = digit_q;
  assign digit_ok = digit_ok_q;
`else
  assign digit    = 4'h0;
  assign digit_ok = 1'b0;
`endif

endmodule

// File: tb/tb_seg_frame_monitor.sv
// Bench for seg_frame_monitor: vector table plus scoreboard of expected accepts, and hand sequences for timeout and reset.
`timescale 1ns/1ps
module tb_seg_frame_monitor;

  localparam int PW = 24;
`ifdef SEG_MON_HEX_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    seg_in;
  logic          frame_valid;
  logic [7:0]    frame_pat;
  logic [3:0]    digit;
  logic          digit_ok;
  logic [PW-1:0] period;
  logic [15:0]   frame_cnt;
  logic          timeout;

  seg_frame_monitor #(.STABLE_CNT(4), .TIMEOUT_CYC(100), .PERIOD_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .frame_valid(frame_valid),
    .frame_pat(frame_pat), .digit(digit), .digit_ok(digit_ok), .period(period),
    .frame_cnt(frame_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    int         hold;
    bit         acc;
    logic [7:0] pat;
    logic [3:0] dig;
    bit         ok;
    int         per;
  } vec_t;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] dig;
    bit         ok;
    int         per;
    int         cnt;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] pat, input logic [3:0] dig, input bit ok, input int per);
    sb_t e;
    exp_cnt++;
    e.pat = pat;
    e.dig = DEC ? dig : 4'h0;
    e.ok  = DEC ? ok : 1'b0;
    e.per = per;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (frame_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got frame_pat 0x%0h expected no pulse", frame_pat);
      end else begin
        e = sb.pop_front();
        chk("pulse_pat", 32'(frame_pat), 32'(e.pat));
        chk("pulse_digit", 32'(digit), 32'(e.dig));
        chk("pulse_digit_ok", 32'(digit_ok), 32'(e.ok));
        chk("pulse_period", 32'(period), 32'(e.per));
        chk("pulse_frame_cnt", 32'(frame_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_frame_pat"}, 32'(frame_pat), 32'd0);
    chk({tag, "_digit"}, 32'(digit), 32'd0);
    chk({tag, "_digit_ok"}, 32'(digit_ok), 32'd0);
    chk({tag, "_period"}, 32'(period), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{8'h06, 10, 1'b1, 8'h06, 4'h1, 1'b1, 0};
    tbl[1]  = '{8'h5B,  3, 1'b0, 8'h06, 4'h0, 1'b0, 0};
    tbl[2]  = '{8'h06, 10, 1'b0, 8'h06, 4'h0, 1'b0, 0};
    tbl[3]  = '{8'h3F, 50, 1'b1, 8'h3F, 4'h0, 1'b1, 23};
    tbl[4]  = '{8'h4F, 10, 1'b1, 8'h4F, 4'h3, 1'b1, 50};
    tbl[5]  = '{8'hBF, 10, 1'b1, 8'hBF, 4'h0, 1'b1, 10};
    tbl[6]  = '{8'h80, 10, 1'b1, 8'h80, 4'h0, 1'b0, 10};
    tbl[7]  = '{8'h7C,  2, 1'b0, 8'h80, 4'h0, 1'b0, 0};
    tbl[8]  = '{8'h71,  8, 1'b1, 8'h71, 4'hF, 1'b1, 12};
    tbl[9]  = '{8'h7D,  4, 1'b1, 8'h71, 4'h6, 1'b1, 8};
    tbl[10] = '{8'h77,  3, 1'b0, 8'h7D, 4'h0, 1'b0, 0};
    tbl[11] = '{8'h79, 10, 1'b1, 8'h79, 4'hE, 1'b1, 7};

    rst_n  = 1'b0;
    seg_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_all_zero("idle_zero");

    // Table pass: frame_pat after each hold; pulses are checked by the scoreboard.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].acc) push_exp(tbl[i].seg, tbl[i].dig, tbl[i].ok, tbl[i].per);
      seg_in = tbl[i].seg;
      repeat (tbl[i].hold) @(posedge clk);
      #1;
      chk($sformatf("vec%0d_frame_pat", i), 32'(frame_pat), 32'(tbl[i].pat));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
    end

    // Long hold: timeout rises once period_ctr reaches 100, accept edge clears it.
    push_exp(8'h5E, 4'hD, 1'b1, 10);
    seg_in = 8'h5E;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk);
      #1;
      if (k == 103) chk("timeout_before_100", 32'(timeout), 32'd0);
      if (k == 104) chk("timeout_at_100", 32'(timeout), 32'd1);
    end
    chk("timeout_held", 32'(timeout), 32'd1);
    chk("long_hold_cnt", 32'(frame_cnt), 32'(exp_cnt));

    push_exp(8'h66, 4'h4, 1'b1, 120);
    seg_in = 8'h66;
    repeat (4) @(posedge clk);
    #1;
    chk("timeout_pre_accept", 32'(timeout), 32'd1);
    chk("valid_pre_accept", 32'(frame_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("timeout_accept_edge", 32'(timeout), 32'd0);
    chk("valid_accept_edge", 32'(frame_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // Reset in the middle of a qualifying run must abort the pending accept.
    seg_in = 8'h4F;
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b0;
    seg_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midrun_reset");
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_all_zero("post_reset_idle");

    exp_cnt = 0;
    push_exp(8'h06, 4'h1, 1'b1, 0);
    seg_in = 8'h06;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_accept_pat", 32'(frame_pat), 32'h06);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_frame_monitor.md
SEG_FRAME_MONITOR -- requirements
Module: seg_frame_monitor

Interface
REQ-001 Parameter: STABLE_CNT, default 4, consecutive identical samples needed to accept a pattern (legal range 2..255).
REQ-002 Parameter: TIMEOUT_CYC, default 1000000, cycles without an accepted change before timeout asserts.
REQ-003 Parameter: PERIOD_W, default 24, width of the period counter and the period output.
REQ-004 Port: clk  input  1  single clock; all logic rising-edge.
REQ-005 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port: seg_in  input  8  observed segment bus {dp,g,f,e,d,c,b,a}, active-high; same bus as the uo_out of the seven-segment display blocks.
REQ-007 Port: frame_valid  output  1  one-cycle pulse on each accepted pattern change.
REQ-008 Port: frame_pat  output  8  last accepted pattern.
REQ-009 Port: digit  output  4  hex value decoded from frame_pat.
REQ-010 Port: digit_ok  output  1  frame_pat[6:0] matches an entry in the hex table.
REQ-011 Port: period  output  PERIOD_W  cycles between the last two accepted changes.
REQ-012 Port: frame_cnt  output  16  count of accepted changes.
REQ-013 Port: timeout  output  1  no accepted change for TIMEOUT_CYC cycles.

Function
REQ-014 seg_in SHALL be registered each cycle (seg_q); all decisions use seg_q only; all outputs registered.
REQ-015 Glitch filter: candidate register plus a run counter that saturates at STABLE_CNT; if seg_q equals the candidate, run counter increments; otherwise candidate loads seg_q and run counter loads 1.
REQ-016 Accept: run counter reaches STABLE_CNT and candidate differs from frame_pat -> frame_pat loads candidate and frame_valid is high for exactly one cycle.
REQ-017 Accept latency: with edge 1 the first edge that registers the new seg_in value, frame_valid and frame_pat update at edge STABLE_CNT+1.
REQ-018 A pattern held for fewer than STABLE_CNT samples SHALL produce no pulse.
REQ-019 A pattern equal to frame_pat SHALL never produce a pulse, however long it is held.
REQ-020 A held pattern SHALL produce exactly one pulse; the saturated run counter does not re-trigger.
REQ-021 period_ctr (PERIOD_W bits) SHALL increment every cycle and saturate at all-ones.
REQ-022 On accept, period_ctr loads 1.
REQ-023 On accept when a prior accept exists since reset, period loads the current period_ctr value.
REQ-024 The first accept after reset SHALL leave period at 0.
REQ-025 frame_cnt SHALL increment on each accept and wrap 0xFFFF -> 0x0000.
REQ-026 timeout SHALL be high while period_ctr >= TIMEOUT_CYC, including before the first accept, and SHALL drop at the accept edge.
REQ-027 Hex table (dp ignored): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-028 For a pattern not in the hex table: digit=0, digit_ok=0.
REQ-029 digit and digit_ok SHALL update in the same cycle as frame_pat.

Reset
REQ-030 While rst_n is low at a rising edge, all registers SHALL clear: seg_q, candidate, run counter, frame_pat=0x00, frame_valid=0, digit=0, digit_ok=0, period=0, period_ctr=0, frame_cnt=0, timeout=0, first-accept flag cleared.
REQ-031 Reset mid-filter or mid-pulse SHALL abort any pending accept; no pulse SHALL follow reset release unless a fresh qualifying pattern arrives.
REQ-032 Pattern 0x00 after reset equals frame_pat and SHALL NOT pulse.

Configuration
REQ-033 Macro SEG_MON_HEX_DECODE_EN defined: hex decode per REQ-027..REQ-029.
REQ-034 Macro SEG_MON_HEX_DECODE_EN undefined: no decode logic is built; digit and digit_ok are tied to 0; all other behaviour is unchanged.

Verification (bench values: STABLE_CNT=4, TIMEOUT_CYC=100, PERIOD_W=24, macro defined unless stated)
REQ-035 Reset then hold seg_in=0x00 for 20 cycles -> all outputs 0, no frame_valid; timeout stays 0 throughout (period_ctr ends at 20, below 100).
REQ-036 seg_in=0x06 held 10 cycles -> one pulse at edge 5, frame_pat=0x06, digit=1, digit_ok=1, frame_cnt=1, period=0.
REQ-037 From 0x06: 0x5B for 3 cycles, then back to 0x06 -> no pulse; frame_pat stays 0x06.
REQ-038 Accept 0x3F, then 0x4F accepted 50 cycles later -> period=50, digit=3, frame_cnt increments by 1; then 0xBF -> digit=0, digit_ok=1; then 0x80 -> digit_ok=0.
REQ-039 Hold one pattern 120 cycles after an accept -> timeout rises when period_ctr reaches 100; next accept clears it at the accept edge.
REQ-040 Macro undefined, seg_in=0x6D held -> frame_valid pulses, frame_pat=0x6D, digit=0, digit_ok=0.
